// File: rtl/prefetch_queue.sv
`timescale 1ns / 1ps
// prefetch_queue: instruction prefetch queue between a 1-cycle-latency instruction
// memory and the decoder. It keeps its own fetch PC, issues sequential word requests
// while space is guaranteed, buffers {pc, instr} pairs, and flushes on redirect.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request and word-aligned address (addr = fetch PC)
//   imem_rdata          instruction word, valid the cycle after a request
//   redirect/redirect_pc flush queue and restart fetch at redirect_pc (bits [1:0] forced 0)
//   out_valid/out_ready head-entry handshake towards the decoder
//   out_instr/out_pc    head entry (NOP / 0 when empty)
//   count               number of queued entries
module prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] Nop  = 32'h0000_0013;

    logic [XLEN-1:0] fpc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;
    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic            push;
    logic            pop;
    logic [CntW:0]   occupancy;

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Reserve a slot for the outstanding response so a request is only issued when
    // its data is guaranteed a place; a same-cycle pop is deliberately not credited.
    assign occupancy = {1'b0, count_q} + (CntW + 1)'(inflight_q);
    assign imem_req  = ~rst & ~redirect & (occupancy < (CntW + 1)'(DEPTH));
    assign imem_addr = fpc_q;

    // A redirect kills both the arriving response and any pop of a flushed entry.
    assign push = inflight_q & ~redirect;
    assign pop  = (count_q != '0) & out_ready & ~redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q      <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (redirect) begin
            fpc_q      <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                fpc_q    <= fpc_q + XLEN'(4);
                req_pc_q <= fpc_q;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= req_pc_q;
        end
    end

    always_comb begin
        out_valid = ~rst & (count_q != '0);
        out_instr = Nop;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = instr_mem[rd_ptr_q];
            out_pc    = pc_mem[rd_ptr_q];
        end
    end

    assign count = count_q;

    // The request rule reserves space, so a push into a full queue is a design bug.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CntW'(DEPTH))));

endmodule

// File: tb/tb_prefetch_queue.sv
`timescale 1ns / 1ps
// tb_prefetch_queue: directed self-checking bench for prefetch_queue (DEPTH=4,
// RESET_PC=0). A ROM model returns 0xA000_0000 + word index one cycle after each
// request. Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_prefetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            redirect = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [$clog2(DEPTH):0] count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    prefetch_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .count      (count)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous ROM; garbage when not requested so stray captures show up.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? rom(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, out_instr, ins);
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr);
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    // Leaves the bench at C0: the first cycle with rst=0.
    task automatic do_reset(input logic ready);
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = ready;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, with a redirect held during reset that must be ignored.
        rst         = 1'b1;
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0500;
        next_cycle();
        next_cycle();
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, NOP);
        check("rst_pc", out_pc, 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Streaming: first entry two cycles after first request, then one per cycle.
        rst      = 1'b0;
        redirect = 1'b0;
        #1;
        check_req("s_c0", 32'h0);
        check("s_c0_valid", 32'(out_valid), 32'd0);
        next_cycle();
        #1;
        check_req("s_c1", 32'h4);
        check("s_c1_valid", 32'(out_valid), 32'd0);
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            #1;
            check_head("s_stream", 32'(4 * k), 32'hA000_0000 + 32'(k));
            check("s_count", 32'(count), 32'd1);
            next_cycle();
        end

        // Consumer stall: fill to DEPTH, requests stop, then drain in order.
        do_reset(1'b0);
        repeat (4) next_cycle();
        #1;
        check("st_c4_count", 32'(count), 32'd3);
        check("st_c4_req", 32'(imem_req), 32'd0);
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        check("st_full_count", 32'(count), 32'd4);
        check("st_full_req", 32'(imem_req), 32'd0);
        out_ready = 1'b1;
        #1;
        check("st_pop_noreq", 32'(imem_req), 32'd0);
        for (int k = 0; k < 7; k++) begin
            #1;
            check_head("st_drain", 32'(4 * k), 32'hA000_0000 + 32'(k));
            if (k == 1) check_req("st_resume", 32'h10);
            next_cycle();
        end

        // Redirect in the cycle that would request 0x8, with a concurrent pop of pc 0.
        do_reset(1'b1);
        next_cycle();
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check("rd_c2_req", 32'(imem_req), 32'd0);
        check_head("rd_c2", 32'h0, 32'hA000_0000);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("rd_c3_count", 32'(count), 32'd0);
        check("rd_c3_valid", 32'(out_valid), 32'd0);
        check_req("rd_c3", 32'h100);
        next_cycle();
        #1;
        check("rd_c4_valid", 32'(out_valid), 32'd0);
        check_req("rd_c4", 32'h104);
        next_cycle();
        #1;
        check_head("rd_c5", 32'h100, 32'hA000_0040);
        next_cycle();
        #1;
        check_head("rd_c6", 32'h104, 32'hA000_0041);
        next_cycle();

        // Back-to-back redirects: only the last target is fetched.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        check("bb_c7_req", 32'(imem_req), 32'd0);
        next_cycle();
        redirect_pc = 32'h0000_0300;
        #1;
        check("bb_c8_req", 32'(imem_req), 32'd0);
        check("bb_c8_count", 32'(count), 32'd0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("bb_c9_valid", 32'(out_valid), 32'd0);
        check_req("bb_c9", 32'h300);
        next_cycle();
        #1;
        check("bb_c10_valid", 32'(out_valid), 32'd0);
        next_cycle();
        #1;
        check_head("bb_c11", 32'h300, 32'hA000_00C0);
        next_cycle();
        #1;
        check_head("bb_c12", 32'h304, 32'hA000_00C1);

        // Reset mid-stream with three entries queued.
        do_reset(1'b0);
        repeat (4) next_cycle();
        #1;
        check("mr_pre_count", 32'(count), 32'd3);
        rst = 1'b1;
        #1;
        check("mr_req", 32'(imem_req), 32'd0);
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_instr", out_instr, NOP);
        check("mr_pc", out_pc, 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("mr_count", 32'(count), 32'd0);
        check("mr_post_valid", 32'(out_valid), 32'd0);
        check_req("mr_restart", 32'h0);
        next_cycle();

        // Fetch PC wrap from 0xFFFF_FFFC to 0x0.
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect = 1'b0;
        #1;
        check_req("wr_top", 32'hFFFF_FFFC);
        next_cycle();
        #1;
        check_req("wr_zero", 32'h0);
        next_cycle();
        #1;
        check_head("wr_h0", 32'hFFFF_FFFC, 32'hDFFF_FFFF);
        next_cycle();
        #1;
        check_head("wr_h1", 32'h0, 32'hA000_0000);
        next_cycle();
        #1;
        check_head("wr_h2", 32'h4, 32'hA000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
